logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit for the ALU datapath. Supersedes the
//  fixed 64-bit combinational OR: eight selectable bitwise ops, WIDTH-generic operands,
//  STAGES-deep elastic pipeline with valid/ready handshake on both sides.
//  Also produces registered zero / all-ones result flags for the ALU flag logic.
// PARAMETERS
//  WIDTH   64  operand/result width in bits (>=1)
//  STAGES  2   pipeline depth = fixed latency in cycles (legal 1..4)
// PORTS
//  clk         in   1      rising-edge clock, the only clock
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      input beat valid
//  in_ready    out  1      unit accepts a beat this cycle
//  in_op       in   3      operation select (encoding below)
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  out_valid   out  1      result beat valid
//  out_ready   in   1      downstream accepts result this cycle
//  out_y       out  WIDTH  result
//  out_zero    out  1      out_y == 0
//  out_ones    out  1      out_y == all ones
// BEHAVIOUR
//  - Op codes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (A & ~B), 7 PASSA (A).
//  - Transfer occurs when valid && ready on a port, sampled at posedge clk.
//  - Stage 1 registers op result and both flags; stages 2..STAGES delay data+flags unchanged.
//  - Latency: beat accepted in cycle N appears on out_* in cycle N+STAGES if never stalled.
//  - Each stage k holds v[k]. Stage k loads when !v[k] || ready of stage k+1;
//    last stage's downstream ready = out_ready. in_ready = !v[1] || stage-1 advance.
//    Ready path is combinational back-to-front; no combinational path in_valid -> out_*.
//  - Throughput: one beat/cycle with out_ready held high; no bubbles inserted.
//  - Stall: out_valid && !out_ready -> out_y/out_zero/out_ones held stable, no beat lost
//    or duplicated; bubbles upstream collapse (stage fills while later stage stalled).
//  - Full: all v[k]=1 and out_ready=0 -> in_ready=0. Simultaneous in/out transfer when
//    full and out_ready=1 is legal and keeps occupancy at STAGES.
//  - Empty pipeline: out_valid=0, in_ready=1 regardless of out_ready.
//  - Data regs update only on stage load; contents undefined-but-stable when v[k]=0
//    (implementation clears them at reset).
//  - Reset (any time, async assert, sync-safe deassert upstream): all v[k]=0,
//    out_valid=0, out_y=0, out_zero=0, out_ones=0; in-flight beats discarded.
//    in_ready=1 during and after reset.
//  - Flags use the exact WIDTH-bit result; WIDTH=1: zero/ones are complementary.
//  - Illegal STAGES: elaboration error ($error in generate).
// STRUCTURE
//  - Package alu_logic_pkg: op encoding localparams/enum (OP_AND..OP_PASSA), op width 3.
//  - Sub-module logic_pipe_stage #(DW): one elastic register slice (valid, data,
//    up_ready/dn_ready); instantiated STAGES times via generate, DW = WIDTH+2.
//  - Top: combinational op mux + flag reduction feeding slice 1.
// TESTING  (WIDTH=64, STAGES=2 unless noted)
//  1 OR 0F0F..0F / F0F0..F0, out_ready=1 -> 2 cycles later out_y=FFFF_FFFF_FFFF_FFFF,
//    out_ones=1, out_zero=0.
//  2 Stream 8 beats back-to-back, all ops on A=1234_5678_9ABC_DEF0 B=0FED_CBA9_8765_4321
//    -> 8 consecutive out_valid cycles, e.g. XOR=1DD9_9DD1_1DD9_9DD1, ANDN=1010_1450_1898_9CD0.
//  3 Backpressure: fill with 3 beats, out_ready=0 for 5 cycles -> in_ready=0 after 2
//    accepted, out_y stable; release -> beats emerge in order, none lost.
//  4 Random out_ready/in_valid 10k beats vs scoreboard model -> exact order/data match.
//  5 Assert rst_n mid-stream with 2 beats in flight -> out_valid=0, out_y=0 immediately;
//    after release first new beat appears with latency 2.
//  6 WIDTH=1, STAGES=1: NOR 0/0 -> out_y=1, out_ones=1, out_zero=0 after 1 cycle.

Source files
------------

// File: rtl/alu_logic_pkg.sv
// alu_logic_pkg: op encoding shared by the pipelined logic unit and its users.
package alu_logic_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;
endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one elastic register slice with valid/ready on both sides.
module logic_pipe_stage #(
  parameter int DW = 66
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);
  logic          v_q, v_d;
  logic [DW-1:0] data_q, data_d;
  always_comb begin
    up_ready = !v_q || dn_ready;
    v_d      = up_ready ? up_valid : v_q;
    data_d   = (up_valid && up_ready) ? up_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end
  assign dn_valid = v_q;
  assign dn_data  = data_q;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: selectable bitwise op plus zero/ones flags, carried through
// a STAGES-deep elastic pipeline.
module logic_unit_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones
);
  localparam int DW = WIDTH + 2;
  logic [WIDTH-1:0] res;
  logic [DW-1:0]    head, tail;
  always_comb begin
    res = in_a;
    case (op_e'(in_op))
      OP_AND:   res = in_a & in_b;
      OP_OR:    res = in_a | in_b;
      OP_XOR:   res = in_a ^ in_b;
      OP_NOR:   res = ~(in_a | in_b);
      OP_NAND:  res = ~(in_a & in_b);
      OP_XNOR:  res = ~(in_a ^ in_b);
      OP_ANDN:  res = in_a & ~in_b;
      default:  res = in_a;
    endcase
  end
  assign head = {~|res, &res, res};
  if (STAGES < 1 || STAGES > 4) begin : g_bad
    $error("logic_unit_pipe: STAGES must be 1..4");
  end
  // Each slice keeps its own handshake nets so the ready chain stays acyclic.
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic          up_valid, up_ready, dn_valid, dn_ready;
    logic [DW-1:0] up_data, dn_data;
    logic_pipe_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data)
    );
    if (k == 0) begin : g_up
      assign up_valid = in_valid;
      assign up_data  = head;
    end else begin : g_up
      assign up_valid = g[k-1].dn_valid;
      assign up_data  = g[k-1].dn_data;
    end
    if (k == STAGES - 1) begin : g_dn
      assign dn_ready = out_ready;
    end else begin : g_dn
      assign dn_ready = g[k+1].up_ready;
    end
  end
  assign in_ready  = g[0].up_ready;
  assign out_valid = g[STAGES-1].dn_valid;
  assign tail      = g[STAGES-1].dn_data;
  assign out_y     = tail[WIDTH-1:0];
  assign out_ones  = tail[WIDTH];
  assign out_zero  = tail[WIDTH+1];
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors for the 64-bit/2-stage and 1-bit/1-stage units.
module tb_logic_unit_pipe;
  import alu_logic_pkg::*;
  localparam logic [63:0] A = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] B = 64'h0FED_CBA9_8765_4321;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_zero, out_ones;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_a = '0, in_b = '0, out_y;
  logic        n_in_valid = 1'b0, n_out_ready = 1'b1;
  logic        n_in_ready, n_out_valid, n_out_zero, n_out_ones;
  logic [2:0]  n_in_op = 3'd0;
  logic [0:0]  n_in_a = '0, n_in_b = '0, n_out_y;
  int vectors = 0, miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp2 [8] = '{64'h0224_4228_8224_4220, 64'h1FFD_DFF9_9FFD_DFF1,
                            64'h1DD9_9DD1_1DD9_9DD1, 64'hE002_2006_6002_200E,
                            64'hFDDB_BDD7_7DDB_BDDF, 64'hE226_622E_E226_622E,
                            64'h1010_1450_1898_9CD0, 64'h1234_5678_9ABC_DEF0};

  logic_unit_pipe #(.WIDTH(64), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones));

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op),
    .in_a(n_in_a), .in_b(n_in_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_y(n_out_y), .out_zero(n_out_zero), .out_ones(n_out_ones));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    int acc, cyc;
    repeat (2) step;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_y", out_y, 64'd0);
    check("rst_flags", 64'({out_zero, out_ones}), 64'd0);
    rst_n = 1'b1;
    step;
    // single OR beat, latency 2
    out_ready = 1'b1;
    drive(1'b1, OP_OR, {8{8'h0F}}, {8{8'hF0}});
    #1 check("t1_in_ready", 64'(in_ready), 64'd1);
    step;
    drive(1'b0, OP_AND, '0, '0);
    #1 check("t1_lat1_valid", 64'(out_valid), 64'd0);
    step;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_y", out_y, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_ones", 64'(out_ones), 64'd1);
    check("t1_zero", 64'(out_zero), 64'd0);
    step;
    // eight ops back to back
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(1'b1, 3'(c), A, B);
      else drive(1'b0, OP_AND, '0, '0);
      #1;
      if (c >= 2) begin
        check($sformatf("t2_valid%0d", c - 2), 64'(out_valid), 64'd1);
        check($sformatf("t2_y%0d", c - 2), out_y, exp2[c-2]);
        check($sformatf("t2_flags%0d", c - 2), 64'({out_zero, out_ones}), 64'd0);
      end
      step;
    end
    check("t2_drained", 64'(out_valid), 64'd0);
    // backpressure with 3 beats
    out_ready = 1'b0;
    drive(1'b1, OP_AND, '1, '0);
    #1 check("t3_acc0", 64'(in_ready), 64'd1);
    step;
    drive(1'b1, OP_PASSA, 64'd2, '0);
    #1 check("t3_acc1", 64'(in_ready), 64'd1);
    step;
    drive(1'b1, OP_NOR, '0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_full_ready", 64'(in_ready), 64'd0);
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_y", out_y, 64'd0);
      check("t3_hold_zero", 64'(out_zero), 64'd1);
      step;
    end
    out_ready = 1'b1;
    #1 check("t3_full_pass_ready", 64'(in_ready), 64'd1);
    check("t3_out0", out_y, 64'd0);
    step;
    drive(1'b0, OP_AND, '0, '0);
    #1 check("t3_out1_valid", 64'(out_valid), 64'd1);
    check("t3_out1", out_y, 64'd2);
    check("t3_out1_flags", 64'({out_zero, out_ones}), 64'd0);
    step;
    check("t3_out2_valid", 64'(out_valid), 64'd1);
    check("t3_out2", out_y, '1);
    check("t3_out2_ones", 64'(out_ones), 64'd1);
    step;
    check("t3_empty", 64'(out_valid), 64'd0);
    // reset with two beats in flight
    drive(1'b1, OP_XOR, A, B);
    step;
    drive(1'b1, OP_AND, A, B);
    step;
    drive(1'b0, OP_AND, '0, '0);
    #1 check("t5_inflight", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1 check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_y", out_y, 64'd0);
    check("t5_rst_ready", 64'(in_ready), 64'd1);
    step;
    rst_n = 1'b1;
    step;
    check("t5_after_valid", 64'(out_valid), 64'd0);
    drive(1'b1, OP_OR, A, B);
    step;
    drive(1'b0, OP_AND, '0, '0);
    #1 check("t5_lat1", 64'(out_valid), 64'd0);
    step;
    check("t5_lat2_valid", 64'(out_valid), 64'd1);
    check("t5_lat2_y", out_y, exp2[1]);
    step;
    // 1-bit, single stage
    check("t6_rst_y", 64'(n_out_y), 64'd0);
    n_in_valid = 1'b1; n_in_op = OP_NOR; n_in_a = 1'b0; n_in_b = 1'b0;
    step;
    n_in_op = OP_XOR; n_in_a = 1'b1; n_in_b = 1'b1;
    #1 check("t6_nor_valid", 64'(n_out_valid), 64'd1);
    check("t6_nor_y", 64'(n_out_y), 64'd1);
    check("t6_nor_ones", 64'(n_out_ones), 64'd1);
    check("t6_nor_zero", 64'(n_out_zero), 64'd0);
    step;
    n_in_valid = 1'b0;
    #1 check("t6_xor_y", 64'(n_out_y), 64'd0);
    check("t6_xor_flags", 64'({n_out_zero, n_out_ones}), 64'd2);
    step;
    // random handshake against the scoreboard
    acc = 0;
    cyc = 0;
    while ((acc < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      in_valid  = (acc < 10000) && ($urandom_range(3) != 0);
      in_op     = 3'($urandom_range(7));
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      out_ready = $urandom_range(3) != 0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_extra", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rand_y", out_y, e);
          check("rand_flags", 64'({out_zero, out_ones}), 64'({e == '0, e == '1}));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_a, in_b));
        acc++;
      end
      step;
      cyc++;
    end
    check("rand_accepted", 64'(acc), 64'd10000);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
